// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the frame-buffer arbiter and its swap controller.
package vga_fb_pkg;

  localparam int ADDR_W_DFLT = 19;
  localparam int DATA_W_DFLT = 15;
  localparam int H_PIXELS    = 640;
  localparam int V_LINES     = 480;
  localparam int DISP_LAT    = 2;

  typedef enum logic {
    SWAP_IDLE,
    SWAP_PENDING
  } swap_state_e;

endpackage

// File: rtl/vga_fb_swap_ctrl.sv
// Front/back buffer swap controller: a swap request is held until the next
// rising edge of vertical blanking, then front_sel toggles.
module vga_fb_swap_ctrl
  import vga_fb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic swap_req_i,
  input  logic vblank_i,
  output logic swap_fire_o,
  output logic swap_pending_o,
  output logic swap_done_o,
  output logic front_sel_o
);

  swap_state_e state_q;
  logic        vblank_q;
  logic        pending_q;
  logic        done_q;
  logic        front_q;

  // Only a rise seen while a swap is pending counts; a request made on a rise waits a frame.
  assign swap_fire_o = (state_q == SWAP_PENDING) && vblank_i && !vblank_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= SWAP_IDLE;
      vblank_q  <= 1'b0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      front_q   <= 1'b0;
    end else begin
      vblank_q <= vblank_i;
      done_q   <= 1'b0;
      case (state_q)
        SWAP_IDLE: begin
          if (swap_req_i) begin
            state_q   <= SWAP_PENDING;
            pending_q <= 1'b1;
          end
        end
        SWAP_PENDING: begin
          if (swap_fire_o) begin
            state_q   <= SWAP_IDLE;
            pending_q <= 1'b0;
            done_q    <= 1'b1;
            front_q   <= ~front_q;
          end
        end
        default: begin
          state_q   <= SWAP_IDLE;
          pending_q <= 1'b0;
        end
      endcase
    end
  end

  assign swap_pending_o = pending_q;
  assign swap_done_o    = done_q;
  assign front_sel_o    = front_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer SRAM arbiter: display reads have strict priority,
// draw-engine writes target the back buffer, swaps happen at vblank.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              disp_vblank,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic              swap_done,
  output logic              front_sel,
  output logic [CNT_W-1:0]  wr_stall_cnt,
  output logic [ADDR_W:0]   mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic              swap_fire;
  logic              wr_fire;
  logic [ADDR_W:0]   mem_addr_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              vld_p0;
  logic              vld_p1;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  stall_q;
  logic [CNT_W-1:0]  stall_d;

  vga_fb_swap_ctrl u_swap_ctrl (
    .clk_i          (clk),
    .rst_ni         (reset_n),
    .swap_req_i     (swap_req),
    .vblank_i       (disp_vblank),
    .swap_fire_o    (swap_fire),
    .swap_pending_o (swap_pending),
    .swap_done_o    (swap_done),
    .front_sel_o    (front_sel)
  );

  assign wr_ready = !disp_req && !swap_pending;
  assign wr_fire  = wr_valid && wr_ready;

  // Request stage: drive the SRAM port; address and data hold when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else if (disp_req) begin
      mem_addr_q <= {front_sel, disp_addr};
      mem_we_q   <= 1'b0;
    end else if (wr_fire) begin
      mem_addr_q  <= {~front_sel, wr_addr};
      mem_wdata_q <= wr_data;
      mem_we_q    <= 1'b1;
    end else begin
      mem_we_q <= 1'b0;
    end
  end

  // Read pipeline: p0 = address issued, p1 = SRAM sampled, then data captured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      vld_p0   <= disp_req;
      vld_p1   <= vld_p0;
      rvalid_q <= vld_p1;
      if (vld_p1) rdata_q <= mem_rdata;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (swap_fire)                  stall_d = '0;
    else if (wr_valid && !wr_ready) stall_d = sat_inc(stall_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign mem_addr     = mem_addr_q;
  assign mem_we       = mem_we_q;
  assign mem_wdata    = mem_wdata_q;
  assign disp_rvalid  = rvalid_q;
  assign disp_rdata   = rdata_q;
  assign wr_stall_cnt = stall_q;

endmodule
